line_serializer: RTL and testbench
==================================

# line_serializer

Critical-word-first cache-line serializer for the read-only cache fill/response path. Captures one full line plus a starting unit index and beat count on a valid/ready handshake, then streams the selected UNIT_WIDTH slices one per accepted beat on a second valid/ready interface. It replaces the one-cycle one-hot slice select with a buffered, back-pressurable, wrap-aware burst engine.

## Interface
- LINE_WIDTH, 32: width of the captured line in bits; must be an integer multiple of UNIT_WIDTH.
- UNIT_WIDTH, 4: width of one output beat in bits.
- BEATS, LINE_WIDTH/UNIT_WIDTH (derived localparam): units per line; must be >= 2.
- IDX_W, $clog2(BEATS) (derived): unit index width.
- LEN_W, $clog2(BEATS)+1 (derived): beat-count width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_line  in  LINE_WIDTH  line data; unit i = in_line[i*UNIT_WIDTH +: UNIT_WIDTH].
- in_start  in  IDX_W  first unit index.
- in_len  in  LEN_W  beats requested; 0 means BEATS; values > BEATS clamp to BEATS.
- out_valid  out  1  beat valid.
- out_ready  in  1  beat consumed when out_valid && out_ready.
- out_data  out  UNIT_WIDTH  current unit.
- out_idx  out  IDX_W  unit index of current beat.
- out_last  out  1  current beat is the final beat of the burst.

## Operation
- States: IDLE, SEND. Reset state IDLE.
- IDLE: in_ready=1, out_valid=0. On accept: line_q<=in_line, ptr<=in_start, rem<=effective length; go SEND.
- SEND: out_valid=1; out_data=line_q unit[ptr]; out_idx=ptr; out_last=(rem==1).
- Beat accept (out_valid && out_ready): ptr<=ptr+1 (wrap BEATS-1 -> 0, not power-of-two wrap), rem<=rem-1.
- Last beat accepted: if in_valid also high, accept the new request in the same cycle (in_ready=1 in that cycle) and stay SEND, no bubble; otherwise go IDLE.
- in_ready = IDLE || (SEND && out_ready && out_last); combinational from state and out_ready.
- While out_valid && !out_ready: out_data, out_idx, out_last held stable.
- in_* fields ignored when not accepted.

## Timing
- Reset values: state IDLE, line_q 0, ptr 0, rem 0; out_valid 0, out_data 0, out_idx 0, out_last 0; in_ready 1 once in IDLE (upstream holds in_valid low during reset).
- Latency: first beat valid the cycle after request accept; with out_ready held high, N beats on N consecutive cycles.
- Throughput: one beat per cycle; back-to-back bursts with zero idle cycles.
- Reset asserted mid-burst: outputs drop to reset values asynchronously; remaining beats discarded; no beat emitted after release until a new request.

## Configuration
- LINE_SERIALIZER_WRAP_EN defined: burst wraps modulo BEATS; effective length = clamp(in_len); start=5, len=8 on BEATS=8 yields 5,6,7,0,1,2,3,4.
- Undefined: no wrap; effective length = min(clamp(in_len), BEATS-in_start); burst ends at unit BEATS-1 with out_last; ptr never wraps.

## Test plan
All with LINE_WIDTH=32, UNIT_WIDTH=4, in_line=0x76543210 (unit i = i).
- start=0, len=8, out_ready=1 -> out_data 0..7 on 8 consecutive cycles starting one cycle after accept; out_last only on data 7; then IDLE, in_ready=1.
- start=5, len=8 -> WRAP_EN: 5,6,7,0,1,2,3,4, last on 4; without macro: 5,6,7, last on 7.
- start=2, len=3, out_ready pattern 1,0,0,1,0,1 -> data 2,3,3,3,4,4 visible; accepted sequence 2,3,4; out_data/out_idx stable during stalls.
- len=0 then immediate second request (line 0xFEDCBA98, start=0, len=2) held valid during first burst -> 8 beats 0..7, next cycle 8, then 9 with last; no idle cycle; in_ready high only in last-beat cycle.
- Reset pulse after 3rd beat of an 8-beat burst -> out_valid=0, out_data=0 immediately; after release, no beats until new request; new request start=7, len=1 -> single beat 7 with out_last=1.

Source files
------------

// File: rtl/line_serializer.sv
// rtl/line_serializer.sv - critical-word-first line serializer; LINE_SERIALIZER_WRAP_EN enables modulo-BEATS wrap
module line_serializer #(
  parameter  int LINE_WIDTH = 32,
  parameter  int UNIT_WIDTH = 4,
  localparam int BEATS      = LINE_WIDTH / UNIT_WIDTH,
  localparam int IDX_W      = $clog2(BEATS),
  localparam int LEN_W      = $clog2(BEATS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LINE_WIDTH-1:0] in_line,
  input  logic [IDX_W-1:0]      in_start,
  input  logic [LEN_W-1:0]      in_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [UNIT_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [LINE_WIDTH-1:0] line_q;
  logic [IDX_W-1:0]      ptr, ptr_inc;
  logic [LEN_W-1:0]      rem;
  logic [LEN_W-1:0]      room, len_clamp, len_eff;
  logic [UNIT_WIDTH-1:0] cur_unit;
  logic                  accept, beat, last_beat;

  assign last_beat = (rem == LEN_W'(1));
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  // Units left between the start index and the top of the line.
  assign room = LEN_W'(BEATS) - {1'b0, in_start};

  // Effective burst length: 0 and oversize requests mean a full line.
  always_comb begin
    len_clamp = in_len;
    if (in_len == '0 || in_len > LEN_W'(BEATS)) len_clamp = LEN_W'(BEATS);
`ifdef LINE_SERIALIZER_WRAP_EN
    len_eff = len_clamp;
`else
    len_eff = len_clamp;
    if (len_clamp > room) len_eff = room;
`endif
  end

  // Pointer advance: modulo BEATS when wrapping, otherwise pinned at the top unit.
`ifdef LINE_SERIALIZER_WRAP_EN
  assign ptr_inc = (ptr == IDX_W'(BEATS - 1)) ? '0 : ptr + 1'b1;
`else
  assign ptr_inc = (ptr == IDX_W'(BEATS - 1)) ? ptr : ptr + 1'b1;
`endif

  // Select the unit addressed by ptr (explicit mux keeps non-power-of-two BEATS safe).
  always_comb begin
    cur_unit = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (ptr == IDX_W'(i)) cur_unit = line_q[i*UNIT_WIDTH +: UNIT_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and request ready; a new request may chain onto the last beat.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        if (out_ready && last_beat) begin
          in_ready = 1'b1;
          if (!in_valid) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst datapath: capture on accept, advance on each consumed beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      ptr    <= '0;
      rem    <= '0;
    end else if (accept) begin
      line_q <= in_line;
      ptr    <= in_start;
      rem    <= len_eff;
    end else if (beat) begin
      ptr    <= ptr_inc;
      rem    <= rem - 1'b1;
    end
  end

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? cur_unit : '0;
  assign out_idx   = out_valid ? ptr : '0;
  assign out_last  = out_valid && last_beat;

endmodule

// File: tb/tb_line_serializer.sv
// tb/tb_line_serializer.sv - randomized and directed self-checking bench for line_serializer
module tb_line_serializer;

  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_line = '0;
  logic [2:0]  in_start = '0;
  logic [3:0]  in_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_last;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int idx;
    int data;
    bit last;
  } beat_t;

  beat_t exp_q[$];

  line_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_line  (in_line),
    .in_start (in_start),
    .in_len   (in_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: expand a request into its list of beats from the burst rules.
  task automatic push_burst(input logic [31:0] line, input int start, input int len);
    int eff;
    int idx;
    eff = (len == 0 || len > BEATS) ? BEATS : len;
`ifndef LINE_SERIALIZER_WRAP_EN
    if (eff > BEATS - start) eff = BEATS - start;
`endif
    for (int k = 0; k < eff; k++) begin
      beat_t b;
      idx    = (start + k) % BEATS;
      b.idx  = idx;
      b.data = int'((line >> (4 * idx)) & 32'hF);
      b.last = (k == eff - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the reference, advance both.
  task automatic step(input bit iv, input logic [31:0] line, input int start, input int len,
                      input bit ordy, output bit accepted);
    bit exp_rdy;
    in_valid  = iv;
    in_line   = line;
    in_start  = 3'(start);
    in_len    = 4'(len);
    out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || (ordy && exp_q[0].last);
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0].data));
      check("out_idx",  32'(out_idx),  32'(exp_q[0].idx));
      check("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    accepted = iv && exp_rdy;
    if (accepted) push_burst(line, start, len);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 0, 0, 1'b1, a);
  endtask

  initial begin
    bit a;
    bit pend;
    logic [31:0] r_line;
    int r_start, r_len;
    bit [5:0] rpat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full line from unit 0.
    step(1'b1, 32'h76543210, 0, 8, 1'b1, a);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 0, 0, 1'b1, a);
    idle(2);

    // Start mid-line with full length: wraps or truncates depending on build.
    step(1'b1, 32'h76543210, 5, 8, 1'b1, a);
    idle(10);

    // Back-pressure pattern 1,0,0,1,0,1.
    step(1'b1, 32'h76543210, 2, 3, 1'b0, a);
    rpat = 6'b101001;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 0, 0, rpat[i], a);
    idle(2);

    // len=0 burst with a second request held valid throughout.
    step(1'b1, 32'h76543210, 0, 0, 1'b1, a);
    for (int i = 0; i < 8; i++) step(1'b1, 32'hFEDCBA98, 0, 2, 1'b1, a);
    idle(4);

    // Asynchronous reset mid-burst, then a single-beat request.
    step(1'b1, 32'h76543210, 0, 8, 1'b1, a);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 0, 0, 1'b1, a);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_out_last",  32'(out_last),  32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    step(1'b1, 32'h76543210, 7, 1, 1'b1, a);
    idle(3);

    // Randomized traffic with random back-pressure and request gaps.
    pend = 1'b0;
    r_line = '0;
    r_start = 0;
    r_len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend    = 1'b1;
        r_line  = $urandom;
        r_start = $urandom_range(0, 7);
        r_len   = $urandom_range(0, 15);
      end
      step(pend, r_line, r_start, r_len, ($urandom_range(0, 3) != 0), a);
      if (a) pend = 1'b0;
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
